// File: rtl/traffic_sense_frontend.sv
// traffic_sense_frontend
// Input conditioning for the highway/country light controller: a time-of-day
// clock with a 1 s prescaler, a day-window flag, a debounced country-road car
// request and an emergency-vehicle override with a seconds-based hold timer.
// Optional build macro: TRAFFIC_EMERG_LOG_EN enables the saturating
// accepted-emergency-event counter on emerg_count (tied to zero otherwise).
module traffic_sense_frontend #(
  parameter int TICK_DIV      = 50000000,
  parameter int DEB_CYCLES    = 500000,
  parameter int EMERG_HOLD_S  = 10,
  parameter int NIGHT_START_H = 21,
  parameter int NIGHT_END_H   = 5
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       car_sense,
  input  logic       emerg_valid,
  input  logic [7:0] emerg_code,
  input  logic       set_time,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  output logic       X,
  output logic       is_true,
  output logic       is_true1,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic       sec_tick,
  output logic [7:0] emerg_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(EMERG_HOLD_S + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(EMERG_HOLD_S);

  localparam logic [7:0] CODE_AMBULANCE = 8'h41;
  localparam logic [7:0] CODE_FIRE      = 8'h46;
  localparam logic [7:0] CODE_POLICE    = 8'h50;

  typedef enum logic {
    E_IDLE,
    E_ACTIVE
  } emerg_state_t;

  // ---------------------------------------------------------------------
  // Prescaler and time of day
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_reg, presc_next;
  logic [5:0]    sec_reg, sec_next;
  logic [5:0]    min_reg, min_next;
  logic [4:0]    hour_reg, hour_next;
  logic          is_true_reg;
  logic          tick;
  logic          set_valid;

  assign tick      = (presc_reg == PRESC_LAST);
  assign set_valid = set_time && (set_hours <= 5'd23) && (set_minutes <= 6'd59);

  // Next time value: a valid load wins over the tick, an invalid load is ignored
  always_comb begin
    presc_next = presc_reg;
    sec_next   = sec_reg;
    min_next   = min_reg;
    hour_next  = hour_reg;
    if (set_valid) begin
      presc_next = '0;
      sec_next   = '0;
      min_next   = set_minutes;
      hour_next  = set_hours;
    end else if (tick) begin
      presc_next = '0;
      if (sec_reg == 6'd59) begin
        sec_next = '0;
        if (min_reg == 6'd59) begin
          min_next  = '0;
          hour_next = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
        end else begin
          min_next = min_reg + 6'd1;
        end
      end else begin
        sec_next = sec_reg + 6'd1;
      end
    end else begin
      presc_next = presc_reg + 1'b1;
    end
  end

  // Time registers plus the day-window flag, which trails hours by one cycle
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      presc_reg   <= '0;
      sec_reg     <= '0;
      min_reg     <= '0;
      hour_reg    <= '0;
      is_true_reg <= 1'b0;
    end else begin
      presc_reg   <= presc_next;
      sec_reg     <= sec_next;
      min_reg     <= min_next;
      hour_reg    <= hour_next;
      is_true_reg <= (hour_reg >= 5'(NIGHT_END_H)) && (hour_reg < 5'(NIGHT_START_H));
    end
  end

  // ---------------------------------------------------------------------
  // Car sensor: two-flop synchronizer followed by a stability counter
  // ---------------------------------------------------------------------
  logic [1:0]    sync_reg;
  logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
  logic          x_reg, x_next;

  // X only follows the synced input after DEB_CYCLES consecutive disagreeing cycles
  always_comb begin
    deb_cnt_next = '0;
    x_next       = x_reg;
    if (sync_reg[1] != x_reg) begin
      if (deb_cnt_reg == DEB_LAST) begin
        x_next = sync_reg[1];
      end else begin
        deb_cnt_next = deb_cnt_reg + 1'b1;
      end
    end
  end

  // Synchronizer chain and debounce state
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync_reg    <= '0;
      deb_cnt_reg <= '0;
      x_reg       <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], car_sense};
      deb_cnt_reg <= deb_cnt_next;
      x_reg       <= x_next;
    end
  end

  // ---------------------------------------------------------------------
  // Emergency override
  // ---------------------------------------------------------------------
  emerg_state_t  state_reg, state_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          code_accept;

  // Police codes only count at night; the registered day flag is the reference
  assign code_accept = emerg_valid &&
                       ((emerg_code == CODE_AMBULANCE) ||
                        (emerg_code == CODE_FIRE) ||
                        ((emerg_code == CODE_POLICE) && !is_true_reg));

  // Next state: a reload beats a decrement, and an expired hold drops to idle
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    case (state_reg)
      E_IDLE: begin
        if (code_accept) begin
          state_next = E_ACTIVE;
          hold_next  = HOLD_LOAD;
        end
      end
      E_ACTIVE: begin
        if (code_accept) begin
          hold_next = HOLD_LOAD;
        end else if (hold_reg == '0) begin
          state_next = E_IDLE;
        end else if (tick) begin
          hold_next = hold_reg - 1'b1;
        end
      end
      default: begin
        state_next = E_IDLE;
        hold_next  = '0;
      end
    endcase
  end

  // Emergency state register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg <= E_IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

`ifdef TRAFFIC_EMERG_LOG_EN
  logic [7:0] emerg_count_reg;

  // Saturating count of every accepted code, reloads included
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      emerg_count_reg <= 8'h00;
    end else if (code_accept && (emerg_count_reg != 8'hFF)) begin
      emerg_count_reg <= emerg_count_reg + 8'h01;
    end
  end

  assign emerg_count = emerg_count_reg;
`else
  assign emerg_count = 8'h00;
`endif

  assign X        = x_reg;
  assign is_true  = is_true_reg;
  assign is_true1 = (state_reg == E_ACTIVE);
  assign hours    = hour_reg;
  assign minutes  = min_reg;
  assign sec_tick = tick;

endmodule

// File: tb/tb_traffic_sense_frontend.sv
// Bench for traffic_sense_frontend: directed scenarios with literal
// expectations, then randomized stimulus, all checked every cycle against a
// behavioural model that tracks time as seconds-of-day.
`timescale 1ns/1ps
module tb_traffic_sense_frontend;
  localparam int TD = 10;
  localparam int DB = 4;
  localparam int HS = 3;
`ifdef TRAFFIC_EMERG_LOG_EN
  localparam int LOG_EN = 1;
`else
  localparam int LOG_EN = 0;
`endif

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       car_sense = 1'b0;
  logic       emerg_valid = 1'b0;
  logic [7:0] emerg_code = 8'h00;
  logic       set_time = 1'b0;
  logic [4:0] set_hours = 5'd0;
  logic [5:0] set_minutes = 6'd0;
  logic       X, is_true, is_true1, sec_tick;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [7:0] emerg_count;

  int compared = 0;
  int mismatched = 0;

  traffic_sense_frontend #(
    .TICK_DIV(TD), .DEB_CYCLES(DB), .EMERG_HOLD_S(HS),
    .NIGHT_START_H(21), .NIGHT_END_H(5)
  ) dut (
    .clock(clock), .clear(clear), .car_sense(car_sense),
    .emerg_valid(emerg_valid), .emerg_code(emerg_code),
    .set_time(set_time), .set_hours(set_hours), .set_minutes(set_minutes),
    .X(X), .is_true(is_true), .is_true1(is_true1), .hours(hours),
    .minutes(minutes), .sec_tick(sec_tick), .emerg_count(emerg_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_presc = 0, m_tod = 0, m_istrue = 0;
  int m_x = 0, m_d1 = 0, m_d2 = 0, m_run = 0;
  int m_active = 0, m_ticks = 0, m_count = 0;
  int t_tick, t_oldh, t_acc, t_sync;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_presc = 0; m_tod = 0; m_istrue = 0;
      m_x = 0; m_d1 = 0; m_d2 = 0; m_run = 0;
      m_active = 0; m_ticks = 0; m_count = 0;
    end else begin
      t_tick = (m_presc == TD - 1);
      t_oldh = m_tod / 3600;
      t_acc  = emerg_valid && ((emerg_code == 8'h41) || (emerg_code == 8'h46) ||
                               ((emerg_code == 8'h50) && !m_istrue));
      t_sync = m_d2;
      // time of day as seconds since midnight
      if (set_time && set_hours <= 23 && set_minutes <= 59) begin
        m_tod = int'(set_hours) * 3600 + int'(set_minutes) * 60;
        m_presc = 0;
      end else if (t_tick) begin
        m_presc = 0;
        m_tod = (m_tod + 1) % 86400;
      end else begin
        m_presc++;
      end
      m_istrue = (t_oldh >= 5) && (t_oldh < 21);
      // input seen two edges ago; X follows after DB disagreeing cycles in a row
      m_d2 = m_d1;
      m_d1 = car_sense;
      if (t_sync != m_x) begin
        m_run++;
        if (m_run == DB) begin m_x = t_sync; m_run = 0; end
      end else begin
        m_run = 0;
      end
      // override lasts until HS ticks since the last accepted code, plus one cycle
      if (t_acc) begin
        m_active = 1; m_ticks = 0;
        if (m_count < 255) m_count++;
      end else if (m_active) begin
        if (m_ticks == HS) m_active = 0;
        else if (t_tick) m_ticks++;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clock) begin
    chk("X", X, m_x);
    chk("is_true", is_true, m_istrue);
    chk("is_true1", is_true1, m_active);
    chk("hours", hours, m_tod / 3600);
    chk("minutes", minutes, (m_tod / 60) % 60);
    chk("sec_tick", sec_tick, m_presc == TD - 1);
    chk("emerg_count", emerg_count, LOG_EN ? m_count : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic strobe(input logic [7:0] c);
    emerg_valid = 1'b1; emerg_code = c;
    cyc(1);
    emerg_valid = 1'b0; emerg_code = 8'h00;
  endtask

  task automatic load(input int h, input int m);
    set_time = 1'b1; set_hours = 5'(h); set_minutes = 6'(m);
    cyc(1);
    set_time = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!sec_tick && n < 3 * TD) begin cyc(1); n++; end
    chk("tick_seen", sec_tick, 1);
    cyc(1);
  endtask

  logic [7:0] codes [6] = '{8'h41, 8'h46, 8'h50, 8'h5A, 8'h50, 8'h41};

  initial begin
    #2 clear = 1'b1;
    cyc(3);
    clear = 1'b0;

    // free-running time from reset
    cyc(600);
    chk("lit_min_after_60s", minutes, 1);
    chk("lit_hr_after_60s", hours, 0);
    chk("lit_istrue_midnight", is_true, 0);

    // asynchronous clear mid-count
    cyc(3);
    #2 clear = 1'b1;
    #1;
    chk("lit_clr_minutes", minutes, 0);
    chk("lit_clr_tick", sec_tick, 0);
    chk("lit_clr_X", X, 0);
    chk("lit_clr_is_true1", is_true1, 0);
    @(posedge clock); #1;
    clear = 1'b0;

    // event log: four accepted codes and one ignored at night
    load(22, 0);
    cyc(2);
    strobe(8'h41); strobe(8'h46); strobe(8'h50); strobe(8'h41); strobe(8'h5A);
    cyc(1);
    chk("lit_emerg_count", emerg_count, LOG_EN ? 4 : 0);
    clear = 1'b1; cyc(1); clear = 1'b0;

    // wrap and day window
    load(23, 59); cyc(600);
    chk("lit_wrap_hr", hours, 0);
    chk("lit_wrap_min", minutes, 0);
    load(4, 59); cyc(600);
    chk("lit_5am_hr", hours, 5);
    chk("lit_5am_istrue_lag", is_true, 0);
    cyc(1);
    chk("lit_5am_istrue", is_true, 1);
    load(25, 10);
    chk("lit_badset_hr", hours, 5);
    chk("lit_badset_min", minutes, 0);
    load(21, 0);
    chk("lit_21_istrue_lag", is_true, 1);
    cyc(1);
    chk("lit_21_istrue", is_true, 0);

    // debounce
    car_sense = 1'b1; cyc(3); car_sense = 1'b0; cyc(10);
    chk("lit_glitch_X", X, 0);
    car_sense = 1'b1; cyc(5);
    chk("lit_rise_X_early", X, 0);
    cyc(1);
    chk("lit_rise_X", X, 1);
    car_sense = 1'b0; cyc(5);
    chk("lit_fall_X_early", X, 1);
    cyc(1);
    chk("lit_fall_X", X, 0);

    // ambulance at noon
    load(12, 0); cyc(2);
    strobe(8'h41);
    chk("lit_A_rise", is_true1, 1);
    wait_tick(); wait_tick(); wait_tick();
    chk("lit_A_hold", is_true1, 1);
    cyc(1);
    chk("lit_A_fall", is_true1, 0);

    // fire reload after second tick
    strobe(8'h41);
    wait_tick(); wait_tick();
    strobe(8'h46);
    cyc(15);
    chk("lit_F_extended", is_true1, 1);
    wait_tick(); wait_tick();
    chk("lit_F_hold", is_true1, 1);
    cyc(1);
    chk("lit_F_fall", is_true1, 0);

    // ignored codes
    cyc(2);
    strobe(8'h5A);
    chk("lit_Z_ignored", is_true1, 0);
    strobe(8'h50);
    chk("lit_P_day_ignored", is_true1, 0);
    load(22, 0); cyc(2);
    strobe(8'h50);
    chk("lit_P_night", is_true1, 1);
    wait_tick(); wait_tick(); wait_tick();
    chk("lit_P_hold", is_true1, 1);
    cyc(1);
    chk("lit_P_fall", is_true1, 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) == 0) begin
        #3 clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
      end else begin
        if ($urandom_range(5) == 0) car_sense = ~car_sense;
        emerg_valid = ($urandom_range(9) == 0);
        emerg_code = ($urandom_range(7) == 0) ? 8'($urandom) : codes[$urandom_range(5)];
        set_time = ($urandom_range(149) == 0);
        case ($urandom_range(3))
          0: begin set_hours = 5'd4;  set_minutes = 6'd59; end
          1: begin set_hours = 5'd20; set_minutes = 6'd59; end
          2: begin set_hours = 5'd23; set_minutes = 6'd59; end
          default: begin set_hours = 5'($urandom); set_minutes = 6'($urandom); end
        endcase
        cyc(1);
        emerg_valid = 1'b0;
        set_time = 1'b0;
      end
    end

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
